alu_ctrl_seq: RTL

//  Registered, handshaked ALU-control stage: decodes ALUOp/IR opcode/funct into an ALU select code.

---
 rtl/alu_ctrl_pkg.sv | 58 +++++
 rtl/alu_ctrl_dec.sv | 56 +++++
 rtl/alu_ctrl_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// ALU-control shared types: ALUOp, select codes, funct/opcode values, FSM states.
// Optional shift decode is enabled by defining ALU_SHIFT_EN.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    AOP_ADD = 2'b00,
    AOP_SUB = 2'b01,
    AOP_R   = 2'b10,
    AOP_I   = 2'b11
  } aluop_e;

  localparam logic [3:0] SEL_PASS = 4'd0;
  localparam logic [3:0] SEL_SUB0 = 4'd1;
  localparam logic [3:0] SEL_ADD  = 4'd2;
  localparam logic [3:0] SEL_SUB  = 4'd3;
  localparam logic [3:0] SEL_AND  = 4'd4;
  localparam logic [3:0] SEL_OR   = 4'd5;
  localparam logic [3:0] SEL_XOR  = 4'd6;
  localparam logic [3:0] SEL_NOR  = 4'd7;
  localparam logic [3:0] SEL_SLT  = 4'd8;
  localparam logic [3:0] SEL_SLL  = 4'd9;
  localparam logic [3:0] SEL_SRL  = 4'd10;
  localparam logic [3:0] SEL_SRA  = 4'd11;
  localparam logic [3:0] SEL_MULT = 4'd12;
  localparam logic [3:0] SEL_DIV  = 4'd13;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FULL    = 2'd1,
    S_MD_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] code;
    logic       is_md;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU-control decode: (alu_op, ir_op, funct) -> code/is_md/illegal.
// Shift functs decode only when ALU_SHIFT_EN is defined.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] ir_op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (alu_op == AOP_ADD): dec.code = SEL_PASS;
      (alu_op == AOP_SUB): dec.code = SEL_SUB0;
      (alu_op == AOP_R): begin
        case (funct)
          F_ADD:  dec.code = SEL_ADD;
          F_SUB:  dec.code = SEL_SUB;
          F_AND:  dec.code = SEL_AND;
          F_OR:   dec.code = SEL_OR;
          F_XOR:  dec.code = SEL_XOR;
          F_NOR:  dec.code = SEL_NOR;
          F_SLT:  dec.code = SEL_SLT;
`ifdef ALU_SHIFT_EN
          F_SLL:  dec.code = SEL_SLL;
          F_SRL:  dec.code = SEL_SRL;
          F_SRA:  dec.code = SEL_SRA;
`endif
          F_MULT: begin
            dec.code  = SEL_MULT;
            dec.is_md = 1'b1;
          end
          F_DIV: begin
            dec.code  = SEL_DIV;
            dec.is_md = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      (alu_op == AOP_I): begin
        case (ir_op)
          OP_ADDI: dec.code = SEL_ADD;
          OP_ANDI: dec.code = SEL_AND;
          OP_ORI:  dec.code = SEL_OR;
          OP_XORI: dec.code = SEL_XOR;
          OP_SLTI: dec.code = SEL_SLT;
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU-control stage with multi-cycle MULT/DIV wait.
// Build option: define ALU_SHIFT_EN to decode SLL/SRL/SRA.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int MD_LAT = 32,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       ir_op,
  input  logic [5:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  alu_sel,
  output logic             illegal,
  output logic             md_start,
  output logic             md_busy,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LD = CW'(MD_LAT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_e        state;
  state_e        state_n;
  logic [CW-1:0] cnt;
  dec_t          dec;
  logic          accept;
  logic          cnt_zero;

  alu_ctrl_dec u_dec (
    .alu_op (alu_op),
    .ir_op  (ir_op),
    .funct  (funct),
    .dec    (dec)
  );

  assign in_ready  = (state == S_IDLE) |
                     ((state == S_FULL) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == S_FULL);
  assign md_busy   = (state == S_MD_WAIT);
  assign cnt_zero  = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_n = dec.is_md ? S_MD_WAIT : S_FULL;
      end
      S_FULL: begin
        if (accept)
          state_n = dec.is_md ? S_MD_WAIT : S_FULL;
        else if (out_ready)
          state_n = S_IDLE;
      end
      S_MD_WAIT: begin
        if (cnt_zero) state_n = S_FULL;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // MULT/DIV codes are loaded at accept; out_valid hides them until done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_sel <= '0;
      illegal <= 1'b0;
    end else if (accept) begin
      alu_sel <= OP_W'(dec.code);
      illegal <= dec.illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_start <= 1'b0;
      cnt      <= '0;
    end else begin
      md_start <= accept & dec.is_md;
      if (accept && dec.is_md)
        cnt <= CNT_LD;
      else if (md_busy && !cnt_zero)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (accept && dec.illegal && (err_cnt != ERR_MAX))
      err_cnt <= err_cnt + 1'b1;
  end

endmodule
